// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int          INSN_BYTES     = 32'sd4;
   localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcn;
      logic [31:0] ins;
   } fetch_entry_t;

   function automatic logic addr_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry queue of fetch entries; flush beats push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t,
   parameter int  DEPTH   = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   input  logic                         flush,
   output entry_t                       head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int              PW     = $clog2(DEPTH);
   localparam int              CW     = $clog2(DEPTH+1);
   localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0]   ZERO_C = CW'(0);

   entry_t          mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            do_push_s;
   logic            do_pop_s;

   // Qualify push/pop against occupancy and drive the head view.
   always_comb begin
      do_push_s = push & (count_r != FULL_C);
      do_pop_s  = pop & (count_r != ZERO_C);
      head      = mem_r[rd_ptr_r];
      empty     = (count_r == ZERO_C);
      count     = count_r;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= ZERO_C;
      end else if (flush) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= ZERO_C;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, ROM request issue, prefetch queue and prioritised redirect.
// FETCH_ALIGN_CHECK_EN enables the misaligned-target flag and halt.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC),
   parameter int                    DEPTH      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic [ADDR_WIDTH-1:0]        imem_addr_out,
   output logic                         imem_req_out,
   input  logic [31:0]                  imem_data_in,
   input  logic                         redirect_reg_in,
   input  logic [ADDR_WIDTH-1:0]        redirect_reg_target_in,
   input  logic                         redirect_br_in,
   input  logic [ADDR_WIDTH-1:0]        redirect_br_target_in,
   output logic                         out_valid_out,
   input  logic                         out_ready_in,
   output logic [ADDR_WIDTH-1:0]        out_pc_out,
   output logic [ADDR_WIDTH-1:0]        out_pcn_out,
   output logic [31:0]                  out_ins_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out,
   output logic                         misaligned_out
);

   localparam int            CW      = $clog2(DEPTH+1);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] pcn;
      logic [31:0]           ins;
   } entry_t;

   logic [ADDR_WIDTH-1:0]   fetch_pc_r;
   logic [ADDR_WIDTH-1:0]   req_pc_r;
   logic                    inflight_r;
   logic                    redirect_s;
   logic [ADDR_WIDTH-1:0]   target_raw_s;
   logic [ADDR_WIDTH-1:0]   target_s;
   logic                    halted_s;
   logic                    issue_s;
   logic                    push_s;
   logic                    pop_s;
   entry_t                  push_data_s;
   entry_t                  head_s;
   logic                    empty_s;
   logic [CW-1:0]           count_s;

`ifdef FETCH_ALIGN_CHECK_EN
   logic                    halted_r;

   // Sticky misalignment halt: any redirect re-evaluates it, nothing else does.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         halted_r <= 1'b0;
      end else if (redirect_s) begin
         halted_r <= addr_misaligned(target_s[1:0]);
      end else begin
         halted_r <= halted_r;
      end
   end
`endif

   // Redirect mux, issue decision and the response kill path.
   always_comb begin
      redirect_s = redirect_reg_in | redirect_br_in;
      if (redirect_reg_in) begin
         target_raw_s = redirect_reg_target_in;
      end else begin
         target_raw_s = redirect_br_target_in;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      target_s       = target_raw_s;
      halted_s       = halted_r;
      misaligned_out = halted_r;
`else
      target_s       = {target_raw_s[ADDR_WIDTH-1:2], target_raw_s[1:0] & 2'b00};
      halted_s       = 1'b0;
      misaligned_out = 1'b0;
`endif
      issue_s = reset & ~redirect_s & ~halted_s &
                (({1'b0, count_s} + {{CW{1'b0}}, inflight_r}) < DEPTH_W);
      push_s          = inflight_r & ~redirect_s;
      push_data_s.pc  = req_pc_r;
      push_data_s.pcn = req_pc_r + ADDR_WIDTH'(INSN_BYTES);
      push_data_s.ins = imem_data_in;
      out_valid_out   = ~empty_s & ~redirect_s;
      pop_s           = out_valid_out & out_ready_in;
      imem_addr_out   = fetch_pc_r;
      imem_req_out    = issue_s;
      out_pc_out      = head_s.pc;
      out_pcn_out     = head_s.pcn;
      out_ins_out     = head_s.ins;
      count_out       = count_s;
   end

   // PC and in-flight tracking; a redirect reloads the PC and drops the outstanding fetch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= RESET_PC;
         inflight_r <= 1'b0;
      end else if (redirect_s) begin
         fetch_pc_r <= target_s;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(INSN_BYTES);
         end
      end
   end

   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .flush     (redirect_s),
      .head      (head_s),
      .empty     (empty_s),
      .count     (count_s)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming/back-pressure table plus redirect, alignment and reset sequences.
module tb_fetch_queue;

   logic        clock;
   logic        reset;
   logic [31:0] imem_addr_out;
   logic        imem_req_out;
   logic [31:0] imem_data_in;
   logic        redirect_reg_in;
   logic [31:0] redirect_reg_target_in;
   logic        redirect_br_in;
   logic [31:0] redirect_br_target_in;
   logic        out_valid_out;
   logic        out_ready_in;
   logic [31:0] out_pc_out;
   logic [31:0] out_pcn_out;
   logic [31:0] out_ins_out;
   logic [2:0]  count_out;
   logic        misaligned_out;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t tbl [19];

   fetch_queue #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0040_0000),
      .DEPTH      (4)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .imem_addr_out          (imem_addr_out),
      .imem_req_out           (imem_req_out),
      .imem_data_in           (imem_data_in),
      .redirect_reg_in        (redirect_reg_in),
      .redirect_reg_target_in (redirect_reg_target_in),
      .redirect_br_in         (redirect_br_in),
      .redirect_br_target_in  (redirect_br_target_in),
      .out_valid_out          (out_valid_out),
      .out_ready_in           (out_ready_in),
      .out_pc_out             (out_pc_out),
      .out_pcn_out            (out_pcn_out),
      .out_ins_out            (out_ins_out),
      .count_out              (count_out),
      .misaligned_out         (misaligned_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Synchronous ROM: word for the presented address appears the following cycle.
   always @(posedge clock) imem_data_in <= rom_word(imem_addr_out);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rdy, input logic rb, input logic [31:0] bt,
                        input logic rr, input logic [31:0] rt);
      out_ready_in           = rdy;
      redirect_br_in         = rb;
      redirect_br_target_in  = bt;
      redirect_reg_in        = rr;
      redirect_reg_target_in = rt;
      #1;
   endtask

   task automatic check_head(input string name, input logic [31:0] pc);
      check({name, "_valid"}, {31'd0, out_valid_out}, 32'd1);
      check({name, "_pc"}, out_pc_out, pc);
      check({name, "_pcn"}, out_pcn_out, pc + 32'd4);
      check({name, "_ins"}, out_ins_out, rom_word(pc));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

      tbl[0]  = '{1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,          3'd0};
      tbl[1]  = '{1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0,          3'd0};
      tbl[2]  = '{1'b1, 1'b1, 32'h0040_0008, 1'b1, 32'h0040_0000, 3'd1};
      tbl[3]  = '{1'b1, 1'b1, 32'h0040_000C, 1'b1, 32'h0040_0004, 3'd1};
      tbl[4]  = '{1'b1, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0008, 3'd1};
      tbl[5]  = '{1'b1, 1'b1, 32'h0040_0014, 1'b1, 32'h0040_000C, 3'd1};
      tbl[6]  = '{1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0010, 3'd1};
      tbl[7]  = '{1'b0, 1'b1, 32'h0040_001C, 1'b1, 32'h0040_0010, 3'd2};
      tbl[8]  = '{1'b0, 1'b0, 32'h0040_0020, 1'b1, 32'h0040_0010, 3'd3};
      for (int i = 9; i < 16; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0040_0020, 1'b1, 32'h0040_0010, 3'd4};
      tbl[16] = '{1'b1, 1'b0, 32'h0040_0020, 1'b1, 32'h0040_0010, 3'd4};
      tbl[17] = '{1'b1, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0014, 3'd3};
      tbl[18] = '{1'b1, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0018, 3'd2};

      // Reset state
      @(negedge clock);
      @(negedge clock);
      #1;
      check("rst_count", {29'd0, count_out}, 32'd0);
      check("rst_valid", {31'd0, out_valid_out}, 32'd0);
      check("rst_req", {31'd0, imem_req_out}, 32'd0);
      check("rst_misaligned", {31'd0, misaligned_out}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Streaming then back-pressure table
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].ready, 1'b0, 32'd0, 1'b0, 32'd0);
         check($sformatf("t%0d_req", i), {31'd0, imem_req_out}, {31'd0, tbl[i].exp_req});
         check($sformatf("t%0d_addr", i), imem_addr_out, tbl[i].exp_addr);
         check($sformatf("t%0d_cnt", i), {29'd0, count_out}, {29'd0, tbl[i].exp_cnt});
         if (tbl[i].exp_valid)
            check_head($sformatf("t%0d", i), tbl[i].exp_pc);
         else
            check($sformatf("t%0d_valid", i), {31'd0, out_valid_out}, 32'd0);
         @(negedge clock);
      end

      // Branch redirect with three entries queued and one in flight
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("br_pre_req", {31'd0, imem_req_out}, 32'd1);
      check("br_pre_addr", imem_addr_out, 32'h0040_0028);
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
      check("br_r_cnt", {29'd0, count_out}, 32'd3);
      check("br_r_valid", {31'd0, out_valid_out}, 32'd0);
      check("br_r_req", {31'd0, imem_req_out}, 32'd0);
      @(negedge clock);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("br_r1_cnt", {29'd0, count_out}, 32'd0);
      check("br_r1_req", {31'd0, imem_req_out}, 32'd1);
      check("br_r1_addr", imem_addr_out, 32'h0040_0100);
      @(negedge clock);
      #1;
      check("br_r2_valid", {31'd0, out_valid_out}, 32'd0);
      @(negedge clock);
      #1;
      check_head("br_r3", 32'h0040_0100);
      @(negedge clock);

      // Register redirect outranks branch redirect
      drive(1'b1, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
      check("prio_valid", {31'd0, out_valid_out}, 32'd0);
      check("prio_req", {31'd0, imem_req_out}, 32'd0);
      @(negedge clock);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("prio_addr", imem_addr_out, 32'h0040_0200);
      check("prio_req1", {31'd0, imem_req_out}, 32'd1);
      @(negedge clock);
      @(negedge clock);
      #1;
      check_head("prio_head", 32'h0040_0200);
      @(negedge clock);

      // Misaligned redirect target
      drive(1'b1, 1'b1, 32'h0040_0102, 1'b0, 32'd0);
      check("mis_r_valid", {31'd0, out_valid_out}, 32'd0);
      @(negedge clock);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis_flag", {31'd0, misaligned_out}, 32'd1);
      check("mis_req", {31'd0, imem_req_out}, 32'd0);
      check("mis_addr", imem_addr_out, 32'h0040_0102);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         check($sformatf("mis_halt%0d_req", i), {31'd0, imem_req_out}, 32'd0);
         check($sformatf("mis_halt%0d_valid", i), {31'd0, out_valid_out}, 32'd0);
         check($sformatf("mis_halt%0d_flag", i), {31'd0, misaligned_out}, 32'd1);
      end
`else
      check("mis_flag", {31'd0, misaligned_out}, 32'd0);
      check("mis_req", {31'd0, imem_req_out}, 32'd1);
      check("mis_addr", imem_addr_out, 32'h0040_0100);
      for (int i = 0; i < 3; i++) @(negedge clock);
`endif
      @(negedge clock);
      drive(1'b1, 1'b1, 32'h0040_0104, 1'b0, 32'd0);
      check("al_r_req", {31'd0, imem_req_out}, 32'd0);
      @(negedge clock);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("al_flag", {31'd0, misaligned_out}, 32'd0);
      check("al_req", {31'd0, imem_req_out}, 32'd1);
      check("al_addr", imem_addr_out, 32'h0040_0104);
      @(negedge clock);
      @(negedge clock);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check_head("al_head", 32'h0040_0104);
      @(negedge clock);
      @(negedge clock);

      // Asynchronous reset while full with a fetch in flight
      #1;
      check("full_cnt", {29'd0, count_out}, 32'd3);
      check("full_req", {31'd0, imem_req_out}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check("arst_cnt", {29'd0, count_out}, 32'd0);
      check("arst_valid", {31'd0, out_valid_out}, 32'd0);
      check("arst_req", {31'd0, imem_req_out}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("rel_req", {31'd0, imem_req_out}, 32'd1);
      check("rel_addr", imem_addr_out, 32'h0040_0000);
      check("rel_cnt", {29'd0, count_out}, 32'd0);
      @(negedge clock);
      #1;
      check("rel1_valid", {31'd0, out_valid_out}, 32'd0);
      check("rel1_cnt", {29'd0, count_out}, 32'd0);
      @(negedge clock);
      #1;
      check_head("rel2", 32'h0040_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
